vga_draw_arbiter: RTL and testbench

VGA_DRAW_ARBITER -- requirements
Module: vga_draw_arbiter

---
 rtl/vga_draw_arbiter_pkg.sv | 21 ++
 rtl/vga_rr_pick.sv | 43 ++++
 rtl/vga_draw_arbiter.sv | 152 +++++++++++++++
 tb/tb_vga_draw_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_draw_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vga_pkg : shared FSM encoding and screen defaults for VGA drawing   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package vga_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_e;

    // 160x120 frame buffer with 3-bit colour
    localparam int c_SCREEN_W = 160;
    localparam int c_SCREEN_H = 120;
    localparam int c_DEF_X_W  = 8;
    localparam int c_DEF_Y_W  = 7;
    localparam int c_DEF_C_W  = 3;

endpackage
`default_nettype wire

// File: rtl/vga_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vga_rr_pick : combinational winner select, fixed or rotating start  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module vga_rr_pick #(
    parameter int NUM_SRC = 3,
    parameter int IDX_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    input  logic               mode_i,
    output logic [NUM_SRC-1:0] winner_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_idx;

    always_comb begin
        winner_o = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        w_sum    = '0;
        w_idx    = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            // Scan starts at ptr in rotating mode, at 0 otherwise, wrapping at NUM_SRC
            w_sum = {1'b0, (mode_i ? ptr_i : {IDX_W{1'b0}})} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(NUM_SRC)) begin
                w_sum = w_sum - (IDX_W+1)'(NUM_SRC);
            end
            w_idx = w_sum[IDX_W-1:0];
            if (!valid_o && req_i[w_idx]) begin
                valid_o         = 1'b1;
                winner_o[w_idx] = 1'b1;
                idx_o           = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_draw_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vga_draw_arbiter : grants one drawing source at a time to the VGA   |
// | adapter and forwards its pixel stream. Rev 1.0                      |
// +--------------------------------------------------------------------+
module vga_draw_arbiter
    import vga_pkg::*;
#(
    parameter int NUM_SRC   = 3,
    parameter int X_W       = c_DEF_X_W,
    parameter int Y_W       = c_DEF_Y_W,
    parameter int C_W       = c_DEF_C_W,
    parameter int RR        = 0,
    parameter int MAX_BURST = 0
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [NUM_SRC-1:0]     src_req,
    input  logic [NUM_SRC-1:0]     src_done,
    input  logic [NUM_SRC-1:0]     src_plot,
    input  logic [NUM_SRC*X_W-1:0] src_x,
    input  logic [NUM_SRC*Y_W-1:0] src_y,
    input  logic [NUM_SRC*C_W-1:0] src_colour,
    output logic [NUM_SRC-1:0]     grant,
    output logic [X_W-1:0]         x,
    output logic [Y_W-1:0]         y,
    output logic [C_W-1:0]         colour,
    output logic                   plot,
    output logic                   busy
);

    localparam int IDX_W = $clog2(NUM_SRC);
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] c_LIMIT = (MAX_BURST > 0) ? CNT_W'(MAX_BURST - 1) : '0;

    logic [X_W-1:0] w_x   [NUM_SRC];
    logic [Y_W-1:0] w_y   [NUM_SRC];
    logic [C_W-1:0] w_col [NUM_SRC];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign w_x[i]   = src_x[i*X_W +: X_W];
        assign w_y[i]   = src_y[i*Y_W +: Y_W];
        assign w_col[i] = src_colour[i*C_W +: C_W];
    end

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [C_W-1:0]     colour_q, colour_d;
    logic               plot_q, plot_d;

    logic [NUM_SRC-1:0] w_win;
    logic [IDX_W-1:0]   w_win_idx;
    logic               w_any;
    logic               w_rr_mode;
    logic               w_release;
    logic [IDX_W-1:0]   w_ptr_next;

    assign w_rr_mode = (RR != 0);

    vga_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i    (src_req),
        .ptr_i    (ptr_q),
        .mode_i   (w_rr_mode),
        .winner_o (w_win),
        .idx_o    (w_win_idx),
        .valid_o  (w_any)
    );

    // Only the owner's done flag or the burst limit ends ownership
    assign w_release  = src_done[owner_q] || ((MAX_BURST > 0) && (cnt_q == c_LIMIT));
    assign w_ptr_next = (owner_q == IDX_W'(NUM_SRC - 1)) ? '0 : owner_q + IDX_W'(1);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_any) begin
                    state_d = OWN;
                    grant_d = w_win;
                    owner_d = w_win_idx;
                    cnt_d   = '0;
                end
            end
            OWN: begin
                x_d      = w_x[owner_q];
                y_d      = w_y[owner_q];
                colour_d = w_col[owner_q];
                plot_d   = src_plot[owner_q];
                if (w_release) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = w_ptr_next;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            owner_q  <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
        end
    end

    assign grant  = grant_q;
    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = (state_q == OWN);

endmodule
`default_nettype wire

// File: tb/tb_vga_draw_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_vga_draw_arbiter : scoreboard bench over fixed-priority,         |
// | round-robin and burst-limited arbiter instances. Rev 1.0            |
// +--------------------------------------------------------------------+
module tb_vga_draw_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic [2:0]  src_req, src_done, src_plot;
    logic [23:0] src_x;
    logic [20:0] src_y;
    logic [8:0]  src_colour;

    localparam logic [23:0] c_X = {8'd30, 8'd10, 8'd5};
    localparam logic [20:0] c_Y = {7'd40, 7'd20, 7'd6};
    localparam logic [8:0]  c_C = {3'd7, 3'd4, 3'd1};

    logic [2:0] fp_grant, rr_grant, mb_grant;
    logic [7:0] fp_x, rr_x, mb_x;
    logic [6:0] fp_y, rr_y, mb_y;
    logic [2:0] fp_c, rr_c, mb_c;
    logic       fp_plot, rr_plot, mb_plot;
    logic       fp_busy, rr_busy, mb_busy;

    vga_draw_arbiter #(.NUM_SRC(3), .RR(0), .MAX_BURST(0)) u_fp (
        .clock(clk), .resetn(resetn), .src_req(src_req), .src_done(src_done),
        .src_plot(src_plot), .src_x(src_x), .src_y(src_y), .src_colour(src_colour),
        .grant(fp_grant), .x(fp_x), .y(fp_y), .colour(fp_c), .plot(fp_plot), .busy(fp_busy)
    );

    vga_draw_arbiter #(.NUM_SRC(3), .RR(1), .MAX_BURST(0)) u_rr (
        .clock(clk), .resetn(resetn), .src_req(src_req), .src_done(src_done),
        .src_plot(src_plot), .src_x(src_x), .src_y(src_y), .src_colour(src_colour),
        .grant(rr_grant), .x(rr_x), .y(rr_y), .colour(rr_c), .plot(rr_plot), .busy(rr_busy)
    );

    vga_draw_arbiter #(.NUM_SRC(3), .RR(0), .MAX_BURST(4)) u_mb (
        .clock(clk), .resetn(resetn), .src_req(src_req), .src_done(src_done),
        .src_plot(src_plot), .src_x(src_x), .src_y(src_y), .src_colour(src_colour),
        .grant(mb_grant), .x(mb_x), .y(mb_y), .colour(mb_c), .plot(mb_plot), .busy(mb_busy)
    );

    typedef struct packed {
        logic [1:0] dut;
        logic [3:0] id;
        logic [2:0] grant;
        logic       plot;
        logic       busy;
        logic       pix;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic string tname(input int id);
        case (id)
            1:       return "reset";
            2:       return "fixed_prio";
            3:       return "round_robin";
            4:       return "mid_reset";
            5:       return "forced_release";
            6:       return "done_new_req";
            default: return "other";
        endcase
    endfunction

    function automatic int px_x(input int s);
        case (s) 0: return 5; 1: return 10; default: return 30; endcase
    endfunction
    function automatic int px_y(input int s);
        case (s) 0: return 6; 1: return 20; default: return 40; endcase
    endfunction
    function automatic int px_c(input int s);
        case (s) 0: return 1; 1: return 4; default: return 7; endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int d, input int id, input int g, input int p, input int b,
                            input int pix, input int ex, input int ey, input int ec);
        exp_t e;
        e.dut   = 2'(d);
        e.id    = 4'(id);
        e.grant = 3'(g);
        e.plot  = 1'(p);
        e.busy  = 1'(b);
        e.pix   = 1'(pix);
        e.x     = 8'(ex);
        e.y     = 7'(ey);
        e.c     = 3'(ec);
        q.push_back(e);
    endtask

    task automatic do_reset();
        resetn   = 1'b0;
        src_req  = 3'b000;
        src_done = 3'b000;
        src_plot = 3'b111;
        src_x    = c_X;
        src_y    = c_Y;
        src_colour = c_C;
        step();
        resetn = 1'b1;
    endtask

    task automatic cmp(input int id, input string what, input logic [7:0] act, input logic [7:0] exv);
        n_chk++;
        if (act !== exv) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h expected %0h", tname(id), what, act, exv);
        end
    endtask

    // Monitor: pops one expectation per falling edge and compares the selected instance
    exp_t       m_e;
    logic [2:0] m_g;
    logic [7:0] m_x;
    logic [6:0] m_y;
    logic [2:0] m_c;
    logic       m_p, m_b;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            m_e = q.pop_front();
            case (m_e.dut)
                2'd0:    begin m_g = fp_grant; m_x = fp_x; m_y = fp_y; m_c = fp_c; m_p = fp_plot; m_b = fp_busy; end
                2'd1:    begin m_g = rr_grant; m_x = rr_x; m_y = rr_y; m_c = rr_c; m_p = rr_plot; m_b = rr_busy; end
                default: begin m_g = mb_grant; m_x = mb_x; m_y = mb_y; m_c = mb_c; m_p = mb_plot; m_b = mb_busy; end
            endcase
            cmp(int'(m_e.id), "grant", {5'd0, m_g}, {5'd0, m_e.grant});
            cmp(int'(m_e.id), "plot",  {7'd0, m_p}, {7'd0, m_e.plot});
            cmp(int'(m_e.id), "busy",  {7'd0, m_b}, {7'd0, m_e.busy});
            if (m_e.pix) begin
                cmp(int'(m_e.id), "x",      m_x,         m_e.x);
                cmp(int'(m_e.id), "y",      {1'b0, m_y}, {1'b0, m_e.y});
                cmp(int'(m_e.id), "colour", {5'd0, m_c}, {5'd0, m_e.c});
            end
        end
    end

    initial begin
        logic [2:0] oh;
        int         o;

        resetn     = 1'b0;
        src_req    = 3'b111;
        src_done   = 3'b000;
        src_plot   = 3'b111;
        src_x      = c_X;
        src_y      = c_Y;
        src_colour = c_C;

        // Reset held for two edges with every source requesting
        step(); push_exp(0, 1, 3'b000, 0, 0, 1, 0, 0, 0);
        step(); push_exp(0, 1, 3'b000, 0, 0, 1, 0, 0, 0);
        resetn = 1'b1;
        step(); push_exp(0, 1, 3'b001, 0, 1, 1, 0, 0, 0);
        step(); push_exp(0, 1, 3'b001, 1, 1, 1, 5, 6, 1);

        // Fixed priority: lowest requester wins; a gap cycle precedes the re-grant
        do_reset();
        src_req = 3'b110;
        step(); push_exp(0, 2, 3'b010, 0, 1, 1, 0, 0, 0);
        step(); push_exp(0, 2, 3'b010, 1, 1, 1, 10, 20, 4);
        src_done = 3'b010;
        step(); push_exp(0, 2, 3'b000, 1, 0, 1, 10, 20, 4);
        src_done = 3'b000;
        step(); push_exp(0, 2, 3'b010, 0, 1, 1, 10, 20, 4);

        // Round-robin rotation with non-owner done in OWN and stray done in IDLE
        do_reset();
        src_req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            o  = k % 3;
            oh = 3'b001 << o;
            step(); push_exp(1, 3, int'(oh), 0, 1, 0, 0, 0, 0);
            src_done = ~oh;
            step(); push_exp(1, 3, int'(oh), 1, 1, 1, px_x(o), px_y(o), px_c(o));
            src_done = oh;
            step(); push_exp(1, 3, 0, 1, 0, 1, px_x(o), px_y(o), px_c(o));
            src_done = 3'b111;
        end

        // Reset during a source-1 burst; pointer restarts at 0
        src_done = 3'b000;
        src_req  = 3'b010;
        step(); push_exp(1, 4, 3'b010, 0, 1, 0, 0, 0, 0);
        src_req = 3'b111;
        step(); push_exp(1, 4, 3'b010, 1, 1, 1, 10, 20, 4);
        resetn = 1'b0;
        step(); push_exp(1, 4, 3'b000, 0, 0, 1, 0, 0, 0);
        resetn = 1'b1;
        step(); push_exp(1, 4, 3'b001, 0, 1, 1, 0, 0, 0);

        // Burst limit of 4 with the owner dropping its request mid-burst
        do_reset();
        src_req = 3'b001;
        step(); push_exp(2, 5, 3'b001, 0, 1, 1, 0, 0, 0);
        src_req = 3'b000;
        step(); push_exp(2, 5, 3'b001, 1, 1, 1, 5, 6, 1);
        step(); push_exp(2, 5, 3'b001, 1, 1, 1, 5, 6, 1);
        step(); push_exp(2, 5, 3'b001, 1, 1, 1, 5, 6, 1);
        src_req = 3'b001;
        step(); push_exp(2, 5, 3'b000, 1, 0, 1, 5, 6, 1);
        step(); push_exp(2, 5, 3'b001, 0, 1, 1, 5, 6, 1);

        // Done from source 0 coinciding with a new request from source 2
        do_reset();
        src_req = 3'b001;
        step(); push_exp(0, 6, 3'b001, 0, 1, 1, 0, 0, 0);
        step(); push_exp(0, 6, 3'b001, 1, 1, 1, 5, 6, 1);
        src_done = 3'b001;
        src_req  = 3'b100;
        src_x    = {8'd30, 8'd10, 8'd99};
        step(); push_exp(0, 6, 3'b000, 1, 0, 1, 99, 6, 1);
        src_done = 3'b000;
        step(); push_exp(0, 6, 3'b100, 0, 1, 1, 99, 6, 1);
        step(); push_exp(0, 6, 3'b100, 1, 1, 1, 30, 40, 7);

        step();
        step();
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
